motor_mixer: RTL and testbench
==============================

Name: motor_mixer

Overview:
- Downstream stage of the three per-axis PID rate controllers (roll, pitch, yaw). Consumes their clamped rate outputs plus the throttle command.
- Mixes them into four quad-X motor drive values and clamps each value to a parameterised range.
- Registered motor values feed the PWM generator.
- Sequenced by a start/wait handshake identical in style to the PID stage, with an "armed" safety gate.

Parameters:
- RATE_BIT_WIDTH, 16, width of signed roll/pitch/yaw rate inputs
- THROTTLE_BIT_WIDTH, 16, width of unsigned throttle input
- MOTOR_BIT_WIDTH, 16, width of unsigned motor outputs
- MOTOR_MIN, 16'd0, lowest motor value driven when armed
- MOTOR_MAX, 16'hFFFF, highest motor value driven when armed

Ports:
- us_clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- throttle  input  THROTTLE_BIT_WIDTH  unsigned collective throttle
- roll_rate  input  RATE_BIT_WIDTH  signed roll PID output
- pitch_rate  input  RATE_BIT_WIDTH  signed pitch PID output
- yaw_rate  input  RATE_BIT_WIDTH  signed yaw PID output
- armed  input  1  motors enabled when 1
- start_flag  input  1  all PID stages complete; begin mix
- wait_flag  input  1  release from COMPLETE back to WAIT
- motor_1  output  MOTOR_BIT_WIDTH  front-left (CW)
- motor_2  output  MOTOR_BIT_WIDTH  front-right (CCW)
- motor_3  output  MOTOR_BIT_WIDTH  rear-right (CW)
- motor_4  output  MOTOR_BIT_WIDTH  rear-left (CCW)
- mixer_active  output  1  high in LATCH through COMPLETE
- mixer_complete  output  1  high only in COMPLETE

Behaviour:
- One clock (us_clk). Asynchronous active-low reset (resetn).
- Reset values: state=WAIT; motor_1..4=0; mixer_active=0; mixer_complete=0; internal accumulators=0. Reset asserted mid-operation takes effect immediately.
- States: WAIT, LATCH, SUM1, SUM2, SUM3, CLAMP, COMPLETE. One-hot encoding; illegal encodings go to WAIT on the next edge.
- Transitions:
  - WAIT -> LATCH when start_flag=1 and armed=1; otherwise stay in WAIT.
  - LATCH -> SUM1 -> SUM2 -> SUM3 -> CLAMP -> COMPLETE, unconditionally.
  - COMPLETE -> WAIT when wait_flag=1; otherwise hold.
- start_flag is ignored outside WAIT. start_flag and wait_flag both high in COMPLETE: go to WAIT; start is seen only in a later WAIT cycle.
- LATCH edge captures throttle and all three rates. Later input changes do not affect the current mix.
- Arithmetic uses 19-bit signed accumulators (acc1..acc4): throttle zero-extended, rates sign-extended. Overflow is impossible at this width.
  - SUM1: acc1=T+R, acc2=T-R, acc3=T-R, acc4=T+R
  - SUM2: acc1+=P, acc2+=P, acc3-=P, acc4-=P
  - SUM3: acc1-=Y, acc2+=Y, acc3-=Y, acc4+=Y
  - CLAMP: each motor_n = MOTOR_MIN if acc<MOTOR_MIN, MOTOR_MAX if acc>MOTOR_MAX, else acc[MOTOR_BIT_WIDTH-1:0]. Comparisons are signed.
- Latency: start_flag sampled at edge 0; motor outputs updated at edge 5; mixer_complete=1 from edge 5.
- Motor outputs hold their last value in WAIT and during recomputation. They change only at the CLAMP edge.
- Safety: armed sampled every cycle. armed=0 in any state forces, at the next edge:
  - motor_1..4=0 (not MOTOR_MIN)
  - state=WAIT
  - mixer_active=0, mixer_complete=0
  - While armed=0, start_flag is ignored.

Test Plan:
- Nominal mix: armed=1, T=1000, R=100, P=50, Y=10, 1-cycle start pulse -> 5 edges later m1=1140, m2=960, m3=840, m4=1060; mixer_complete=1 until wait_flag pulse, then 0 the next edge with motors held.
- Low clamp: T=100, R=-32768, P=Y=0 -> m1=0, m2=32868, m3=32868, m4=0.
- High clamp: T=65535, R=32767, P=32767, Y=-32768 -> m1=65535, m2=32767, m3=32769, m4=32767.
- Latch/ignore: change all inputs to 0 and pulse start during SUM2 -> outputs match the latched values; no restart; start+wait both high in COMPLETE -> WAIT, no new mix.
- Disarm mid-op: armed drops during SUM1 after a prior mix of 1140/960/840/1060 -> next edge motors=0, state WAIT, mixer_active=0; start with armed=0 has no effect.
- Reset mid-op: resetn low during SUM3 -> all outputs 0 immediately (before the clock edge); after release, a normal mix completes with correct values.

Source files
------------

// File: rtl/motor_mixer_if.sv
// Bundle of mixer inputs (PID rates, throttle, handshake) and motor outputs.
// master drives the commands; slave is the mixer itself.
interface motor_mixer_if #(
    parameter int RATE_BIT_WIDTH     = 16,
    parameter int THROTTLE_BIT_WIDTH = 16,
    parameter int MOTOR_BIT_WIDTH    = 16
);
    logic        [THROTTLE_BIT_WIDTH-1:0] throttle;
    logic signed [RATE_BIT_WIDTH-1:0]     roll_rate;
    logic signed [RATE_BIT_WIDTH-1:0]     pitch_rate;
    logic signed [RATE_BIT_WIDTH-1:0]     yaw_rate;
    logic                                 armed;
    logic                                 start_flag;
    logic                                 wait_flag;
    logic        [MOTOR_BIT_WIDTH-1:0]    motor_1;
    logic        [MOTOR_BIT_WIDTH-1:0]    motor_2;
    logic        [MOTOR_BIT_WIDTH-1:0]    motor_3;
    logic        [MOTOR_BIT_WIDTH-1:0]    motor_4;
    logic                                 mixer_active;
    logic                                 mixer_complete;

    modport master (
        output throttle, roll_rate, pitch_rate, yaw_rate, armed, start_flag, wait_flag,
        input  motor_1, motor_2, motor_3, motor_4, mixer_active, mixer_complete
    );

    modport slave (
        input  throttle, roll_rate, pitch_rate, yaw_rate, armed, start_flag, wait_flag,
        output motor_1, motor_2, motor_3, motor_4, mixer_active, mixer_complete
    );
endinterface

// File: rtl/motor_mixer.sv
// Quad-X motor mixer: latches throttle and PID rates, accumulates the four motor
// sums over three cycles, clamps them, and gates everything on the armed input.
module motor_mixer #(
    parameter int                         RATE_BIT_WIDTH     = 16,
    parameter int                         THROTTLE_BIT_WIDTH = 16,
    parameter int                         MOTOR_BIT_WIDTH    = 16,
    parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MIN          = 16'd0,
    parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MAX          = 16'hFFFF
) (
    input  logic          us_clk,
    input  logic          resetn,
    motor_mixer_if.slave  bus
);
    // Three signed terms on top of an unsigned throttle need 3 bits of headroom.
    localparam int ACC_W = ((THROTTLE_BIT_WIDTH > RATE_BIT_WIDTH) ?
                            THROTTLE_BIT_WIDTH : RATE_BIT_WIDTH) + 3;

    typedef enum logic [6:0] {
        S_WAIT     = 7'b0000001,
        S_LATCH    = 7'b0000010,
        S_SUM1     = 7'b0000100,
        S_SUM2     = 7'b0001000,
        S_SUM3     = 7'b0010000,
        S_CLAMP    = 7'b0100000,
        S_COMPLETE = 7'b1000000
    } state_t;

    state_t                               state;
    logic        [THROTTLE_BIT_WIDTH-1:0] thr_l;
    logic signed [RATE_BIT_WIDTH-1:0]     roll_l;
    logic signed [RATE_BIT_WIDTH-1:0]     pitch_l;
    logic signed [RATE_BIT_WIDTH-1:0]     yaw_l;
    logic signed [ACC_W-1:0]              acc1, acc2, acc3, acc4;
    logic        [MOTOR_BIT_WIDTH-1:0]    m1_q, m2_q, m3_q, m4_q;
    logic                                 active_q, complete_q;

    function automatic logic signed [ACC_W-1:0] zext_thr(input logic [THROTTLE_BIT_WIDTH-1:0] v);
        return $signed({{(ACC_W-THROTTLE_BIT_WIDTH){1'b0}}, v});
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_rate(input logic signed [RATE_BIT_WIDTH-1:0] v);
        return $signed({{(ACC_W-RATE_BIT_WIDTH){v[RATE_BIT_WIDTH-1]}}, v});
    endfunction

    function automatic logic [MOTOR_BIT_WIDTH-1:0] clamp_motor(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] lo;
        logic signed [ACC_W-1:0] hi;
        lo = $signed({{(ACC_W-MOTOR_BIT_WIDTH){1'b0}}, MOTOR_MIN});
        hi = $signed({{(ACC_W-MOTOR_BIT_WIDTH){1'b0}}, MOTOR_MAX});
        if (acc < lo)      return MOTOR_MIN;
        else if (acc > hi) return MOTOR_MAX;
        else               return acc[MOTOR_BIT_WIDTH-1:0];
    endfunction

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_WAIT;
            thr_l      <= '0;
            roll_l     <= '0;
            pitch_l    <= '0;
            yaw_l      <= '0;
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            acc4       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            m4_q       <= '0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
        end else if (!bus.armed) begin
            // Disarm overrides everything: motors go fully off, not to MOTOR_MIN.
            state      <= S_WAIT;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            m4_q       <= '0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (bus.start_flag) begin
                        state    <= S_LATCH;
                        active_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    thr_l   <= bus.throttle;
                    roll_l  <= bus.roll_rate;
                    pitch_l <= bus.pitch_rate;
                    yaw_l   <= bus.yaw_rate;
                    state   <= S_SUM1;
                end
                S_SUM1: begin
                    acc1  <= zext_thr(thr_l) + sext_rate(roll_l);
                    acc2  <= zext_thr(thr_l) - sext_rate(roll_l);
                    acc3  <= zext_thr(thr_l) - sext_rate(roll_l);
                    acc4  <= zext_thr(thr_l) + sext_rate(roll_l);
                    state <= S_SUM2;
                end
                S_SUM2: begin
                    acc1  <= acc1 + sext_rate(pitch_l);
                    acc2  <= acc2 + sext_rate(pitch_l);
                    acc3  <= acc3 - sext_rate(pitch_l);
                    acc4  <= acc4 - sext_rate(pitch_l);
                    state <= S_SUM3;
                end
                S_SUM3: begin
                    acc1  <= acc1 - sext_rate(yaw_l);
                    acc2  <= acc2 + sext_rate(yaw_l);
                    acc3  <= acc3 - sext_rate(yaw_l);
                    acc4  <= acc4 + sext_rate(yaw_l);
                    state <= S_CLAMP;
                end
                S_CLAMP: begin
                    m1_q       <= clamp_motor(acc1);
                    m2_q       <= clamp_motor(acc2);
                    m3_q       <= clamp_motor(acc3);
                    m4_q       <= clamp_motor(acc4);
                    complete_q <= 1'b1;
                    state      <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    if (bus.wait_flag) begin
                        state      <= S_WAIT;
                        active_q   <= 1'b0;
                        complete_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_WAIT;
                    active_q   <= 1'b0;
                    complete_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_1        = m1_q;
    assign bus.motor_2        = m2_q;
    assign bus.motor_3        = m3_q;
    assign bus.motor_4        = m4_q;
    assign bus.mixer_active   = active_q;
    assign bus.mixer_complete = complete_q;
endmodule

// File: tb/tb_motor_mixer.sv
// Bench for motor_mixer: directed vector table, hand-built handshake/safety/reset
// sequences, and randomized mixes against a plain-arithmetic reference.
module tb_motor_mixer;
    localparam int MMIN = 0;
    localparam int MMAX = 65535;

    logic us_clk;
    logic resetn;

    motor_mixer_if mif();

    motor_mixer dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (mif.slave)
    );

    initial begin
        us_clk = 1'b0;
        forever #5 us_clk = ~us_clk;
    end

    typedef struct {
        string              nm;
        logic [15:0]        t;
        logic signed [15:0] r;
        logic signed [15:0] p;
        logic signed [15:0] y;
        int                 e1, e2, e3, e4;
    } vec_t;

    vec_t tbl[4];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   prev1 = 0, prev2 = 0, prev3 = 0, prev4 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_motors(input string nm, input int e1, input int e2, input int e3, input int e4);
        chk({nm, "_m1"}, int'(mif.motor_1), e1);
        chk({nm, "_m2"}, int'(mif.motor_2), e2);
        chk({nm, "_m3"}, int'(mif.motor_3), e3);
        chk({nm, "_m4"}, int'(mif.motor_4), e4);
    endtask

    function automatic int clampm(input int a);
        if (a < MMIN) return MMIN;
        if (a > MMAX) return MMAX;
        return a;
    endfunction

    // Quad-X mix: each motor is throttle plus/minus each axis, then clamped.
    task automatic model(input int t, input int r, input int p, input int y,
                         output int e1, output int e2, output int e3, output int e4);
        e1 = clampm(t + r + p - y);
        e2 = clampm(t - r + p + y);
        e3 = clampm(t - r - p - y);
        e4 = clampm(t + r - p + y);
    endtask

    task automatic drive(input logic [15:0] t, input logic signed [15:0] r,
                         input logic signed [15:0] p, input logic signed [15:0] y);
        mif.throttle   = t;
        mif.roll_rate  = r;
        mif.pitch_rate = p;
        mif.yaw_rate   = y;
    endtask

    // Full mix with a 1-cycle start pulse; checks hold before edge 5 and results after it.
    task automatic run_mix(input string nm, input logic [15:0] t, input logic signed [15:0] r,
                           input logic signed [15:0] p, input logic signed [15:0] y,
                           input int e1, input int e2, input int e3, input int e4);
        @(negedge us_clk);
        drive(t, r, p, y);
        mif.armed      = 1'b1;
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        chk({nm, "_active"}, int'(mif.mixer_active), 1);
        repeat (4) @(negedge us_clk);
        chk({nm, "_early_cpl"}, int'(mif.mixer_complete), 0);
        chk_motors({nm, "_hold"}, prev1, prev2, prev3, prev4);
        @(negedge us_clk);
        chk({nm, "_cpl"}, int'(mif.mixer_complete), 1);
        chk_motors(nm, e1, e2, e3, e4);
        prev1 = e1; prev2 = e2; prev3 = e3; prev4 = e4;
    endtask

    task automatic release_mix(input string nm);
        mif.wait_flag = 1'b1;
        @(negedge us_clk);
        mif.wait_flag = 1'b0;
        chk({nm, "_rel_cpl"}, int'(mif.mixer_complete), 0);
        chk({nm, "_rel_act"}, int'(mif.mixer_active), 0);
        chk_motors({nm, "_rel"}, prev1, prev2, prev3, prev4);
    endtask

    initial begin
        int e1, e2, e3, e4;
        logic [15:0]        rt;
        logic signed [15:0] rr, rp, ry;

        tbl[0] = '{"nominal", 16'd1000, 16'sd100, 16'sd50, 16'sd10, 1140, 960, 840, 1060};
        tbl[1] = '{"low_clamp", 16'd100, -16'sd32768, 16'sd0, 16'sd0, 0, 32868, 32868, 0};
        tbl[2] = '{"high_clamp", 16'd65535, 16'sd32767, 16'sd32767, -16'sd32768, 65535, 32767, 32769, 32767};
        tbl[3] = '{"mixed_sign", 16'd500, -16'sd200, 16'sd300, -16'sd100, 700, 900, 500, 0};

        resetn         = 1'b0;
        mif.armed      = 1'b0;
        mif.start_flag = 1'b0;
        mif.wait_flag  = 1'b0;
        drive(16'd0, 16'sd0, 16'sd0, 16'sd0);
        repeat (2) @(negedge us_clk);
        chk("reset_active", int'(mif.mixer_active), 0);
        chk("reset_cpl", int'(mif.mixer_complete), 0);
        chk_motors("reset", 0, 0, 0, 0);
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_mix(tbl[i].nm, tbl[i].t, tbl[i].r, tbl[i].p, tbl[i].y,
                    tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].e4);
            repeat (2) @(negedge us_clk);
            chk({tbl[i].nm, "_held_cpl"}, int'(mif.mixer_complete), 1);
            release_mix(tbl[i].nm);
        end

        // Inputs zeroed and start re-pulsed mid-mix must not disturb the latched operands.
        @(negedge us_clk);
        drive(16'd1000, 16'sd100, 16'sd50, 16'sd10);
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        repeat (2) @(negedge us_clk);
        drive(16'd0, 16'sd0, 16'sd0, 16'sd0);
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        repeat (2) @(negedge us_clk);
        chk("latch_cpl", int'(mif.mixer_complete), 1);
        chk_motors("latch", 1140, 960, 840, 1060);
        prev1 = 1140; prev2 = 960; prev3 = 840; prev4 = 1060;
        repeat (3) @(negedge us_clk);
        chk("latch_no_restart", int'(mif.mixer_complete), 1);
        mif.start_flag = 1'b1;
        mif.wait_flag  = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        mif.wait_flag  = 1'b0;
        chk("both_cpl", int'(mif.mixer_complete), 0);
        chk("both_act", int'(mif.mixer_active), 0);
        repeat (7) @(negedge us_clk);
        chk("both_no_mix", int'(mif.mixer_active), 0);
        chk_motors("both_hold", 1140, 960, 840, 1060);

        // Disarm during SUM1 after a completed mix.
        @(negedge us_clk);
        drive(16'd2000, 16'sd10, 16'sd20, 16'sd30);
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        @(negedge us_clk);
        mif.armed = 1'b0;
        @(negedge us_clk);
        chk_motors("disarm", 0, 0, 0, 0);
        chk("disarm_act", int'(mif.mixer_active), 0);
        chk("disarm_cpl", int'(mif.mixer_complete), 0);
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        repeat (7) @(negedge us_clk);
        chk("disarm_start_act", int'(mif.mixer_active), 0);
        chk("disarm_start_cpl", int'(mif.mixer_complete), 0);
        chk_motors("disarm_start", 0, 0, 0, 0);
        prev1 = 0; prev2 = 0; prev3 = 0; prev4 = 0;
        mif.armed = 1'b1;

        // Reset asserted during SUM3 clears outputs without waiting for a clock edge.
        run_mix("pre_rst", 16'd1000, 16'sd100, 16'sd50, 16'sd10, 1140, 960, 840, 1060);
        release_mix("pre_rst");
        @(negedge us_clk);
        drive(16'd3000, 16'sd1, 16'sd2, 16'sd3);
        mif.start_flag = 1'b1;
        @(negedge us_clk);
        mif.start_flag = 1'b0;
        repeat (3) @(negedge us_clk);
        resetn = 1'b0;
        #1;
        chk_motors("async_rst", 0, 0, 0, 0);
        chk("async_rst_act", int'(mif.mixer_active), 0);
        chk("async_rst_cpl", int'(mif.mixer_complete), 0);
        @(negedge us_clk);
        resetn = 1'b1;
        prev1 = 0; prev2 = 0; prev3 = 0; prev4 = 0;
        run_mix("post_rst", tbl[3].t, tbl[3].r, tbl[3].p, tbl[3].y, 700, 900, 500, 0);
        release_mix("post_rst");

        for (int k = 0; k < 30; k++) begin
            rt = 16'($urandom);
            rr = 16'($urandom);
            rp = 16'($urandom);
            ry = 16'($urandom);
            model(int'(rt), int'(rr), int'(rp), int'(ry), e1, e2, e3, e4);
            run_mix($sformatf("rand%0d", k), rt, rr, rp, ry, e1, e2, e3, e4);
            release_mix($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
